rom_stream_ctrl: RTL and testbench
==================================

Name: rom_stream_ctrl

Overview:
Read sequencer for the synchronous ROM (1-cycle registered read, enable-gated). On a start command it issues a burst of consecutive ROM reads from a base address and streams the words out over a valid/ready interface. A 2-entry output buffer absorbs the ROM read latency and downstream backpressure, so no word is lost or duplicated. It sits between the ROM and a consumer such as a weight loader or PE feeder.

Parameters:
ADDR_WIDTH, 4, ROM address width; must equal the ROM instance's ADDR_WIDTH
DATA_WIDTH, 8, ROM word width

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  burst request; sampled only when busy=0
base_addr  in  ADDR_WIDTH  first ROM address of the burst
len  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH
busy  out  1  burst in progress
done  out  1  one-cycle pulse when the burst completes
rom_en  out  1  to ROM en
rom_addr  out  ADDR_WIDTH  to ROM addr
rom_data  in  DATA_WIDTH  from ROM data; valid the cycle after rom_en=1
out_valid  out  1  stream word valid
out_data  out  DATA_WIDTH  stream word
out_last  out  1  qualifies the final word of the burst
out_ready  in  1  consumer accepts the word

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, rom_en, out_valid, out_last = 0; rom_addr=0; out_data=0; buffer emptied; any in-flight read discarded. This applies mid-burst as well.
- States: IDLE, RUN.
- IDLE: start=1 with len!=0 -> latch base_addr and len, clear the issue and accept counters, go to RUN. busy=1 from the next cycle.
- IDLE: start=1 with len=0 -> stay in IDLE, no ROM access, done=1 in the next cycle.
- RUN: start is ignored.
- Issue rule, combinational in RUN: rom_en = (issued<len) && (occ + inflight - pop) < 2.
  - occ: buffer occupancy, 0..2.
  - inflight: rom_en was 1 in the previous cycle.
  - pop: out_valid && out_ready.
- rom_addr = base_addr + issued, modulo 2**ADDR_WIDTH (wraps 2**ADDR_WIDTH-1 -> 0). Held at the last value when rom_en=0.
- The word read by rom_en in cycle t is present on rom_data in cycle t+1 and is written into the buffer at the end of t+1. Buffer order is FIFO.
- Latency: start sampled at edge E0; first rom_en in cycle 1; first out_valid in cycle 3.
- Throughput: 1 word per cycle while out_ready=1.
- Stream rules:
  - out_valid = occ!=0; out_data = buffer head.
  - While out_valid=1 and out_ready=0, out_valid, out_data and out_last hold stable.
  - out_valid never drops without a handshake.
  - A push and a pop in the same cycle leave occ unchanged.
- out_last = out_valid && (accepted == len-1).
- Completion: at the edge of the handshake with out_last=1, state goes to IDLE and done is set.
  - done=1 and busy=0 for exactly that following cycle.
  - start is accepted in that same cycle.
- Invariants:
  - occ + inflight <= 2 at all times.
  - issued <= len.
  - The number of rom_en pulses per burst equals len exactly.

Test Plan:
1. ROM mem[i]=0x10+i; base=0, len=4, out_ready=1 -> rom_en in cycles 1-4 with addr 0..3; out_data 10,11,12,13 in cycles 3-6; out_last with 13; done in cycle 7.
2. Wrap-around: base=14, len=4 -> rom_addr 14,15,0,1; output 1E,1F,10,11.
3. Backpressure: len=8, out_ready held 0 for cycles 3-8, then 1 -> rom_en stops once occ+inflight=2; out_data=10 stable throughout the stall; exactly 10..17 delivered once each, in order.
4. len=0 -> no rom_en; done pulse the cycle after start; busy stays 0.
5. start pulsed mid-burst is ignored (output count unchanged); start asserted in the done cycle launches a new burst immediately.
6. rst_n low mid-burst (after 3 words) -> outputs 0 immediately; after release, a len=2 burst from base 5 returns 15,16 correctly. Also a full sweep len=16 with random out_ready delivers all 16 words in order.

Source files
------------

// File: rtl/rom_stream_ctrl.sv
// Burst read sequencer for a 1-cycle registered ROM, streaming words out over valid/ready.
// A 2-entry FIFO absorbs the read latency and downstream backpressure.
module rom_stream_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ADDR_WIDTH:0] ONE = 1;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   addr_hold;
  logic [ADDR_WIDTH:0]     len_q;
  logic [ADDR_WIDTH:0]     issued;
  logic [ADDR_WIDTH:0]     accepted;
  logic                    inflight;
  logic [1:0]              occ;
  logic [DATA_WIDTH-1:0]   buf_mem [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic                    done_q;
  logic                    pop;
  logic                    push;
  logic                    finish;
  logic                    launch;
  logic                    zero_req;

  assign busy      = (state == RUN);
  assign done      = done_q;
  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? buf_mem[rd_ptr] : '0;
  assign out_last  = out_valid && (accepted == len_q - ONE);
  assign pop       = out_valid && out_ready;
  assign push      = inflight;
  assign finish    = (state == RUN) && pop && out_last;
  assign rom_addr  = rom_en ? (base_q + issued[ADDR_WIDTH-1:0]) : addr_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A read may only be issued if the word it returns is guaranteed a buffer slot,
  // counting the word already in flight and any word leaving this cycle.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    zero_req  = 1'b0;
    rom_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            launch    = 1'b1;
            state_nxt = RUN;
          end else begin
            zero_req = 1'b1;
          end
        end
      end
      RUN: begin
        rom_en = (issued < len_q) &&
                 (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
        if (finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      len_q     <= '0;
      issued    <= '0;
      accepted  <= '0;
      inflight  <= 1'b0;
      addr_hold <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= finish || zero_req;
      inflight <= rom_en;
      if (rom_en) addr_hold <= rom_addr;
      if (launch) begin
        base_q   <= base_addr;
        len_q    <= len;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (rom_en) issued   <= issued + ONE;
        if (pop)    accepted <= accepted + ONE;
      end
    end
  end

  // Output FIFO: the returning ROM word is captured the cycle after its read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= rom_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Scoreboard bench for rom_stream_ctrl: directed bursts push expected words/addresses,
// negedge monitors pop and compare against what the DUT presents.
module tb_rom_stream_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done, rom_en, out_valid, out_last, out_ready;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, out_data;

  rom_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom_mem [16];
  initial for (int i = 0; i < 16; i++) rom_mem[i] = 8'h10 + 8'(i);
  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, c0 = 0;
  int en_cnt, pop_cnt, done_cnt, first_en_rel, first_valid_rel, done_rel;
  logic busy_seen;
  logic [8:0]    exp_q [$];
  logic [AW-1:0] addr_q [$];
  logic          prev_stall = 1'b0, prev_last;
  logic [DW-1:0] prev_data;
  int   ready_mode = 0;
  logic forced_ready = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Single driver of out_ready: 0 = always ready, 1 = random, 2 = forced value.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = forced_ready;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [8:0]    ew;
    logic [AW-1:0] ea;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        checkOutput("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
      if (rom_en) begin
        en_cnt++;
        if (en_cnt == 1) first_en_rel = cyc - c0 + 1;
        if (addr_q.size() == 0) checkOutput("unexpected_rom_en", addr_q.size(), 1);
        else begin
          ea = addr_q.pop_front();
          checkOutput("rom_addr", rom_addr, ea);
        end
      end
      if (out_valid && first_valid_rel == 0) first_valid_rel = cyc - c0 + 1;
      if (busy) busy_seen = 1'b1;
      if (done) begin
        done_cnt++;
        done_rel = cyc - c0 + 1;
        checkOutput("done_busy_low", busy, 0);
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) checkOutput("unexpected_word", exp_q.size(), 1);
        else begin
          ew = exp_q.pop_front();
          checkOutput("out_word", {out_last, out_data}, ew);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Drives start for one edge from the current time; expectations queued first.
  task automatic applyStimulus(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), 8'h10 + 8'((b + i) % 16)});
      addr_q.push_back(AW'((b + i) % 16));
    end
    start = 1'b1; base_addr = b; len = (AW+1)'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
    en_cnt = 0; pop_cnt = 0; done_cnt = 0;
    first_en_rel = 0; first_valid_rel = 0; done_rel = 0; busy_seen = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!done && n < bound);
    if (!done) checkOutput("done_timeout", done, 1);
  endtask

  task automatic finishBurst(input int n);
    checkOutput("rom_en_count", en_cnt, n);
    checkOutput("words_out", pop_cnt, n);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    checkOutput("addr_q_empty", addr_q.size(), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    #1;
    checkOutput("reset_ctrl", {busy, done, rom_en, out_valid, out_last}, 0);
    checkOutput("reset_data", {rom_addr, out_data}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic burst and latency
    applyStimulus(4'd0, 4);
    waitDone(50);
    checkOutput("t1_first_en_cycle", first_en_rel, 1);
    checkOutput("t1_first_valid_cycle", first_valid_rel, 3);
    checkOutput("t1_done_cycle", done_rel, 7);
    finishBurst(4);

    // 2: address wrap-around
    @(posedge clk); #1;
    applyStimulus(4'd14, 4);
    waitDone(50);
    finishBurst(4);

    // 3: backpressure during cycles 3-8
    @(posedge clk); #1;
    ready_mode = 2; forced_ready = 1'b0;
    applyStimulus(4'd0, 8);
    repeat (7) @(posedge clk);
    #2;
    checkOutput("t3_en_during_stall", en_cnt, 2);
    forced_ready = 1'b1;
    waitDone(80);
    finishBurst(8);
    ready_mode = 0;

    // 4: zero-length request
    @(posedge clk); #1;
    applyStimulus(4'd3, 0);
    waitDone(10);
    checkOutput("t4_done_cycle", done_rel, 1);
    repeat (3) @(negedge clk);
    checkOutput("t4_done_once", done_cnt, 1);
    checkOutput("t4_busy_never", busy_seen, 0);
    finishBurst(0);

    // 5: mid-burst start ignored, then relaunch in the done cycle
    @(posedge clk); #1;
    applyStimulus(4'd0, 4);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 4'd8; len = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(50);
    finishBurst(4);
    applyStimulus(4'd2, 3);
    waitDone(50);
    checkOutput("t5_relaunch_first_en", first_en_rel, 1);
    finishBurst(3);

    // 6: reset mid-burst, recovery, random-ready full sweep
    @(posedge clk); #1;
    applyStimulus(4'd0, 8);
    n = 0;
    while (pop_cnt < 3 && n < 50) begin @(negedge clk); #1; n++; end
    checkOutput("t6_words_before_reset", pop_cnt, 3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_reset_ctrl", {busy, done, rom_en, out_valid, out_last}, 0);
    checkOutput("t6_reset_data", {rom_addr, out_data}, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(4'd5, 2);
    waitDone(50);
    finishBurst(2);

    @(posedge clk); #1;
    ready_mode = 1;
    applyStimulus(4'd0, 16);
    waitDone(400);
    finishBurst(16);
    ready_mode = 0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
